split_mixed_result_fifo: RTL

- Downstream stage of the conditional-select register stage: captures its 8-bit value plus 1-bit status each cycle the producer qualifies it valid.
- Buffers entries in a small show-ahead FIFO with a valid/ready output.
- Keeps statistics: accepted status=1 entries and dropped entries.
- Decouples the free-running select stage from a back-pressuring consumer.

---
 rtl/split_mixed_pkg.sv | 13 +
 rtl/split_sat_counter.sv | 35 +++
 rtl/split_mixed_result_fifo.sv | 111 +++++++++++
 3 files changed

// File: rtl/split_mixed_pkg.sv
// Shared types for the split-mixed result FIFO: entry layout and its reset value.
package split_mixed_pkg;

    localparam int DATA_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic              status;
    } split_entry_t;

    localparam split_entry_t ENTRY_RST = '0;

endpackage

// File: rtl/split_sat_counter.sv
// Event counter with synchronous clear; either wraps or sticks at all-ones.
module split_sat_counter #(
    parameter int W        = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && !(SATURATE && (&count_q))) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/split_mixed_result_fifo.sv
// Show-ahead FIFO behind the conditional-select stage, with hit and drop statistics.
module split_mixed_result_fifo
    import split_mixed_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16,
    parameter int DROP_W = 8
) (
    input  logic                     clk_e,
    input  logic                     rst_e,
    input  logic                     in_valid_e,
    input  logic [DATA_W-1:0]        in_val_e,
    input  logic                     in_status_e,
    input  logic                     out_ready_e,
    output logic                     out_valid_e,
    output logic [DATA_W-1:0]        out_val_e,
    output logic                     out_status_e,
    output logic                     full_e,
    output logic                     empty_e,
    output logic [$clog2(DEPTH):0]   count_e,
    output logic [CNT_W-1:0]         hit_count_e,
    output logic [DROP_W-1:0]        drop_count_e
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    split_entry_t mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;

    logic         push;
    logic         pop;
    logic         drop;
    split_entry_t head;

    assign full_e      = (count_q == OCC_W'(DEPTH));
    assign empty_e     = (count_q == '0);
    assign out_valid_e = !empty_e;
    assign count_e     = count_q;

    // A pop frees the slot the incoming entry needs, so full does not block it.
    assign pop  = out_valid_e && out_ready_e;
    assign push = in_valid_e && (!full_e || pop);
    assign drop = in_valid_e && !push;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_e) begin
        if (rst_e) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the cleared pointers make stale contents unreachable.
    always_ff @(posedge clk_e) begin
        if (push) begin
            mem[wr_ptr_q] <= '{val: in_val_e, status: in_status_e};
        end
    end

    assign head         = out_valid_e ? mem[rd_ptr_q] : ENTRY_RST;
    assign out_val_e    = head.val;
    assign out_status_e = head.status;

    split_sat_counter #(
        .W        (CNT_W),
        .SATURATE (1'b0)
    ) u_hit_cnt (
        .clk   (clk_e),
        .srst  (rst_e),
        .inc   (push && in_status_e),
        .clear (1'b0),
        .count (hit_count_e)
    );

    split_sat_counter #(
        .W        (DROP_W),
        .SATURATE (1'b1)
    ) u_drop_cnt (
        .clk   (clk_e),
        .srst  (rst_e),
        .inc   (drop),
        .clear (1'b0),
        .count (drop_count_e)
    );

endmodule
